// File: rtl/uart_prog_loader_if.sv
// uart_prog_loader_if
//   Bundles the byte stream from the UART receiver, the ACK byte to the UART
//   transmitter and the BRAM write port used by the boot-time program loader.
//
//   Signals:
//     rx_valid   1       one-cycle strobe, rx_data holds a new byte
//     rx_data    8       received byte
//     tx_valid   1       ACK byte available, held until tx_ready
//     tx_data    8       ACK byte (8'hAA ok, 8'h55 error)
//     tx_ready   1       transmitter accepts tx_data while tx_valid=1
//     mem_we     1       BRAM write enable, single-cycle pulse per word
//     mem_wadr   ADDR_W  BRAM word address
//     mem_wdata  32      BRAM write data
//
//   Handshake rules:
//     rx side  : no back-pressure; every cycle with rx_valid=1 carries one byte.
//     tx side  : valid/ready. Once tx_valid rises, tx_valid and tx_data hold
//                steady until the first cycle with tx_valid && tx_ready; that
//                cycle transfers the byte and tx_valid drops on the next one.
//     mem side : fire-and-forget; mem_we=1 writes mem_wdata at mem_wadr.
//
//   Modports:
//     master : the loader (consumes rx bytes, drives tx and the BRAM port)
//     slave  : the surrounding UART/BRAM side
interface uart_prog_loader_if #(
  parameter int ADDR_W = 20
);
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              tx_valid;
  logic [7:0]        tx_data;
  logic              tx_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_wadr;
  logic [31:0]       mem_wdata;

  modport master (
    input  rx_valid,
    input  rx_data,
    input  tx_ready,
    output tx_valid,
    output tx_data,
    output mem_we,
    output mem_wadr,
    output mem_wdata
  );

  modport slave (
    output rx_valid,
    output rx_data,
    output tx_ready,
    input  tx_valid,
    input  tx_data,
    input  mem_we,
    input  mem_wadr,
    input  mem_wdata
  );
endinterface

// File: rtl/uart_prog_loader.sv
// uart_prog_loader
//   Boot-time program loader sitting between the UART byte receiver and the
//   instruction/data BRAM. Accepts a frame of the form
//     N (4 bytes, LSB first) | N words (4 bytes each, LSB first) | checksum byte
//   where the checksum is the mod-256 sum of the payload bytes only. Payload
//   words are written to BRAM starting at BASE_WADR. After the checksum byte a
//   one-byte ACK is sent (8'hAA ok, 8'h55 error); on success core_run rises and
//   releases the core from reset.
//
//   Ports:
//     clk        system clock
//     rst        asynchronous, active-high reset
//     bus        uart_prog_loader_if.master (rx bytes, tx ACK, BRAM write)
//     core_run   1 = load succeeded, stays high until reset
//     load_err   sticky length / checksum error flag
//     state_dbg  current FSM state (HDR=0 DATA=1 CSUM=2 ACK=3 DONE=4 ERR=5)
module uart_prog_loader #(
  parameter int              ADDR_W    = 20,
  parameter int              BASE_WADR = 0,
  parameter longint unsigned MAX_WORDS = 64'd1 << ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  uart_prog_loader_if.master    bus,
  output logic                  core_run,
  output logic                  load_err,
  output logic [2:0]            state_dbg
);

  localparam logic [2:0] S_HDR  = 3'd0;
  localparam logic [2:0] S_DATA = 3'd1;
  localparam logic [2:0] S_CSUM = 3'd2;
  localparam logic [2:0] S_ACK  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;
  localparam logic [2:0] S_ERR  = 3'd5;

  localparam logic [7:0]        ACK_OK  = 8'hAA;
  localparam logic [7:0]        ACK_BAD = 8'h55;
  localparam logic [32:0]       MAX_N   = 33'(MAX_WORDS);
  localparam logic [ADDR_W-1:0] BASE_A  = ADDR_W'(BASE_WADR);
  localparam logic [ADDR_W:0]   ONE_W   = (ADDR_W+1)'(1);

  logic [2:0]        state;
  logic [1:0]        byte_cnt;   // byte position within the current 4-byte group
  logic [23:0]       asm_buf;    // first three bytes of the group, LSB first
  logic [ADDR_W:0]   n_words;    // accepted word count (N <= MAX_WORDS)
  logic [ADDR_W:0]   word_idx;   // words already handed to the write register
  logic [7:0]        sum;
  logic              ok;         // result of the checksum compare, used after ACK

  logic              tx_valid_r;
  logic [7:0]        tx_data_r;
  logic              mem_we_r;
  logic [ADDR_W-1:0] mem_wadr_r;
  logic [31:0]       mem_wdata_r;

  // Bytes shift in from the top, so after three bytes the buffer holds
  // {b2,b1,b0} and the arriving fourth byte completes the little-endian word.
  logic [31:0] asm_full;
  assign asm_full = {bus.rx_data, asm_buf};

  logic        last_byte;
  assign last_byte = (byte_cnt == 2'd3);

  logic [ADDR_W:0] word_next;
  assign word_next = word_idx + ONE_W;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_HDR;
      byte_cnt    <= 2'd0;
      asm_buf     <= 24'd0;
      n_words     <= '0;
      word_idx    <= '0;
      sum         <= 8'd0;
      ok          <= 1'b0;
      tx_valid_r  <= 1'b0;
      tx_data_r   <= 8'd0;
      mem_we_r    <= 1'b0;
      mem_wadr_r  <= '0;
      mem_wdata_r <= 32'd0;
      core_run    <= 1'b0;
      load_err    <= 1'b0;
    end else begin
      // Write strobe is a single-cycle pulse; it is re-armed only on the
      // fourth byte of a word.
      mem_we_r <= 1'b0;

      case (state)
        S_HDR: begin
          if (bus.rx_valid) begin
            asm_buf  <= asm_full[31:8];
            byte_cnt <= byte_cnt + 2'd1;
            if (last_byte) begin
              if ({1'b0, asm_full} > MAX_N) begin
                tx_data_r  <= ACK_BAD;
                tx_valid_r <= 1'b1;
                load_err   <= 1'b1;
                ok         <= 1'b0;
                state      <= S_ACK;
              end else if (asm_full == 32'd0) begin
                state <= S_CSUM;
              end else begin
                n_words <= asm_full[ADDR_W:0];
                state   <= S_DATA;
              end
            end
          end
        end

        S_DATA: begin
          if (bus.rx_valid) begin
            asm_buf  <= asm_full[31:8];
            sum      <= sum + bus.rx_data;
            byte_cnt <= byte_cnt + 2'd1;
            if (last_byte) begin
              // The write register is separate from asm_buf, so the byte
              // arriving during the write cycle starts the next word.
              mem_we_r    <= 1'b1;
              mem_wdata_r <= asm_full;
              mem_wadr_r  <= BASE_A + word_idx[ADDR_W-1:0];
              word_idx    <= word_next;
              if (word_next == n_words) begin
                state <= S_CSUM;
              end
            end
          end
        end

        S_CSUM: begin
          if (bus.rx_valid) begin
            tx_valid_r <= 1'b1;
            state      <= S_ACK;
            if (bus.rx_data == sum) begin
              tx_data_r <= ACK_OK;
              ok        <= 1'b1;
            end else begin
              tx_data_r <= ACK_BAD;
              ok        <= 1'b0;
              load_err  <= 1'b1;
            end
          end
        end

        S_ACK: begin
          if (bus.tx_ready) begin
            tx_valid_r <= 1'b0;
            core_run   <= ok;
            state      <= ok ? S_DONE : S_ERR;
          end
        end

        S_DONE: begin
          state <= S_DONE;
        end

        S_ERR: begin
          load_err <= 1'b1;
          state    <= S_ERR;
        end

        default: begin
          state <= S_HDR;
        end
      endcase
    end
  end

  assign bus.tx_valid  = tx_valid_r;
  assign bus.tx_data   = tx_data_r;
  assign bus.mem_we    = mem_we_r;
  assign bus.mem_wadr  = mem_wadr_r;
  assign bus.mem_wdata = mem_wdata_r;
  assign state_dbg     = state;

endmodule

// File: tb/tb_uart_prog_loader.sv
// tb_uart_prog_loader
//   Table of whole-frame vectors on a 20-bit-address loader, plus hand-written
//   sequences: oversize header on a 4-bit-address loader, ACK back-pressure,
//   bytes dropped after DONE and a reset in the middle of DATA.
module tb_uart_prog_loader;
  localparam int AW  = 20;
  localparam int AWS = 4;

  localparam logic [2:0] S_HDR  = 3'd0;
  localparam logic [2:0] S_DATA = 3'd1;
  localparam logic [2:0] S_DONE = 3'd4;
  localparam logic [2:0] S_ERR  = 3'd5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_prog_loader_if #(.ADDR_W(AW))  bus ();
  uart_prog_loader_if #(.ADDR_W(AWS)) bus_s ();

  logic       core_run, load_err;
  logic [2:0] state_dbg;
  logic       core_run_s, load_err_s;
  logic [2:0] state_dbg_s;

  uart_prog_loader #(.ADDR_W(AW), .BASE_WADR(0)) dut (
    .clk(clk), .rst(rst), .bus(bus.master),
    .core_run(core_run), .load_err(load_err), .state_dbg(state_dbg)
  );

  uart_prog_loader #(.ADDR_W(AWS), .BASE_WADR(0)) dut_s (
    .clk(clk), .rst(rst), .bus(bus_s.master),
    .core_run(core_run_s), .load_err(load_err_s), .state_dbg(state_dbg_s)
  );

  // ---------------- vector table ----------------
  typedef struct {
    int              n;
    logic [3:0][31:0] w;
    logic [7:0]      csum;
    int              gap;
    int              ready_dly;
    logic [7:0]      exp_tx;
    logic            exp_run;
    logic            exp_err;
  } vec_t;

  vec_t vecs[6];

  int checks = 0;
  int errors = 0;
  int write_cnt = 0;
  int write_cnt_s = 0;
  logic prev_we = 1'b0;

  logic [AW+31:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // ---------------- scoreboard on the BRAM port ----------------
  always @(negedge clk) begin
    if (bus.mem_we) begin
      write_cnt++;
      check("we_single_cycle", 64'(prev_we), 64'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_write", 64'd1, 64'd0);
      end else begin
        check("write_adr_data", 64'({bus.mem_wadr, bus.mem_wdata}), 64'(exp_q.pop_front()));
      end
    end
    prev_we = bus.mem_we;
    if (bus_s.mem_we) write_cnt_s++;
  end

  // ---------------- drivers ----------------
  task automatic send_byte(input logic [7:0] b, input int gap);
    @(negedge clk);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    if (gap > 0) begin
      @(negedge clk);
      bus.rx_valid = 1'b0;
      repeat (gap - 1) @(negedge clk);
    end
  endtask

  task automatic send_byte_s(input logic [7:0] b);
    @(negedge clk);
    bus_s.rx_valid = 1'b1;
    bus_s.rx_data  = b;
    @(negedge clk);
    bus_s.rx_valid = 1'b0;
  endtask

  task automatic rx_idle();
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.rx_valid = 1'b0;
    rst = 1'b1;
    #2;
    check("rst_tx_valid", 64'(bus.tx_valid), 64'd0);
    check("rst_mem_we", 64'(bus.mem_we), 64'd0);
    check("rst_core_run", 64'(core_run), 64'd0);
    check("rst_load_err", 64'(load_err), 64'd0);
    check("rst_state", 64'(state_dbg), 64'(S_HDR));
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic run_frame(input int idx);
    vec_t        v;
    logic [31:0] nn;
    logic [7:0]  held;
    int          t;
    v  = vecs[idx];
    nn = 32'(v.n);
    for (int i = 0; i < 4; i++) send_byte(nn[8*i +: 8], v.gap);
    for (int wi = 0; wi < v.n; wi++) begin
      exp_q.push_back({AW'(wi), v.w[wi]});
      for (int b = 0; b < 4; b++) send_byte(v.w[wi][8*b +: 8], v.gap);
    end
    send_byte(v.csum, v.gap);
    rx_idle();
    t = 0;
    while (t < 20 && !bus.tx_valid) begin
      @(negedge clk);
      t++;
    end
    check($sformatf("v%0d_tx_valid_up", idx), 64'(bus.tx_valid), 64'd1);
    check($sformatf("v%0d_tx_data", idx), 64'(bus.tx_data), 64'(v.exp_tx));
    check($sformatf("v%0d_run_in_ack", idx), 64'(core_run), 64'd0);
    held = bus.tx_data;
    for (int c = 0; c < v.ready_dly; c++) begin
      @(negedge clk);
      check($sformatf("v%0d_hold_valid", idx), 64'(bus.tx_valid), 64'd1);
      check($sformatf("v%0d_hold_data", idx), 64'(bus.tx_data), 64'(held));
      check($sformatf("v%0d_hold_run", idx), 64'(core_run), 64'd0);
    end
    bus.tx_ready = 1'b1;
    @(negedge clk);
    bus.tx_ready = 1'b0;
    check($sformatf("v%0d_tx_valid_down", idx), 64'(bus.tx_valid), 64'd0);
    check($sformatf("v%0d_core_run", idx), 64'(core_run), 64'(v.exp_run));
    check($sformatf("v%0d_load_err", idx), 64'(load_err), 64'(v.exp_err));
    check($sformatf("v%0d_state", idx), 64'(state_dbg), 64'(v.exp_run ? S_DONE : S_ERR));
    check($sformatf("v%0d_writes_left", idx), 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int wc;
    // Checksums are the mod-256 sum of the payload bytes:
    //   13 00 00 00 78 56 34 12            -> 0x127 -> 27
    //   EF BE AD DE 01 00 00 00 A5 x4      -> 0x5CD -> CD
    //   FF x4                              -> 0x3FC -> FC
    vecs[0] = '{n: 2, w: {32'h0, 32'h0, 32'h12345678, 32'h00000013}, csum: 8'h27,
                gap: 1, ready_dly: 10, exp_tx: 8'hAA, exp_run: 1'b1, exp_err: 1'b0};
    vecs[1] = '{n: 2, w: {32'h0, 32'h0, 32'h12345678, 32'h00000013}, csum: 8'h8C,
                gap: 1, ready_dly: 0, exp_tx: 8'h55, exp_run: 1'b0, exp_err: 1'b1};
    vecs[2] = '{n: 0, w: {32'h0, 32'h0, 32'h0, 32'h0}, csum: 8'h00,
                gap: 0, ready_dly: 0, exp_tx: 8'hAA, exp_run: 1'b1, exp_err: 1'b0};
    vecs[3] = '{n: 3, w: {32'h0, 32'hA5A5A5A5, 32'h00000001, 32'hDEADBEEF}, csum: 8'hCD,
                gap: 0, ready_dly: 2, exp_tx: 8'hAA, exp_run: 1'b1, exp_err: 1'b0};
    vecs[4] = '{n: 1, w: {32'h0, 32'h0, 32'h0, 32'hFFFFFFFF}, csum: 8'hFC,
                gap: 2, ready_dly: 0, exp_tx: 8'hAA, exp_run: 1'b1, exp_err: 1'b0};
    vecs[5] = '{n: 0, w: {32'h0, 32'h0, 32'h0, 32'h0}, csum: 8'h01,
                gap: 0, ready_dly: 1, exp_tx: 8'h55, exp_run: 1'b0, exp_err: 1'b1};

    rst = 1'b1;
    bus.rx_valid = 1'b0;   bus.rx_data = 8'd0;   bus.tx_ready = 1'b0;
    bus_s.rx_valid = 1'b0; bus_s.rx_data = 8'd0; bus_s.tx_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("init_mem_we", 64'(bus.mem_we), 64'd0);
    check("init_mem_wadr", 64'(bus.mem_wadr), 64'd0);
    check("init_mem_wdata", 64'(bus.mem_wdata), 64'd0);
    check("init_tx_data", 64'(bus.tx_data), 64'd0);
    check("init_state_s", 64'(state_dbg_s), 64'(S_HDR));
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      do_reset();
      wc = write_cnt;
      run_frame(i);
      check($sformatf("v%0d_write_count", i), 64'(write_cnt - wc), 64'(vecs[i].n));
    end

    // Bytes arriving in DONE are dropped.
    do_reset();
    run_frame(0);
    wc = write_cnt;
    for (int i = 0; i < 9; i++) send_byte(8'(i * 17), 0);
    rx_idle();
    repeat (2) @(negedge clk);
    check("done_no_writes", 64'(write_cnt - wc), 64'd0);
    check("done_state", 64'(state_dbg), 64'(S_DONE));
    check("done_tx_valid", 64'(bus.tx_valid), 64'd0);
    check("done_core_run", 64'(core_run), 64'd1);

    // Reset in the middle of DATA, then a fresh frame.
    do_reset();
    exp_q.push_back({AW'(0), 32'h44332211});
    send_byte(8'h03, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
    send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0); send_byte(8'h44, 0);
    send_byte(8'h55, 0);
    rx_idle();
    repeat (2) @(negedge clk);
    check("mid_first_word", 64'(exp_q.size()), 64'd0);
    check("mid_state", 64'(state_dbg), 64'(S_DATA));
    do_reset();
    run_frame(3);

    // Oversize header on the 4-bit loader: N=17 > 16.
    do_reset();
    send_byte_s(8'h11); send_byte_s(8'h00); send_byte_s(8'h00); send_byte_s(8'h00);
    check("big_tx_valid", 64'(bus_s.tx_valid), 64'd1);
    check("big_tx_data", 64'(bus_s.tx_data), 64'h55);
    check("big_load_err", 64'(load_err_s), 64'd1);
    bus_s.tx_ready = 1'b1;
    @(negedge clk);
    bus_s.tx_ready = 1'b0;
    check("big_tx_down", 64'(bus_s.tx_valid), 64'd0);
    check("big_state", 64'(state_dbg_s), 64'(S_ERR));
    check("big_core_run", 64'(core_run_s), 64'd0);
    check("big_no_writes", 64'(write_cnt_s), 64'd0);

    // N=16 is exactly the limit and is accepted.
    do_reset();
    send_byte_s(8'h10); send_byte_s(8'h00); send_byte_s(8'h00); send_byte_s(8'h00);
    check("max_state", 64'(state_dbg_s), 64'(S_DATA));
    check("max_tx_valid", 64'(bus_s.tx_valid), 64'd0);
    check("max_load_err", 64'(load_err_s), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
